// File: rtl/note_player_pkg.sv
// Shared widths, state encoding and the note-to-phase-increment table for the music player.
package note_player_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;
    localparam int unsigned STEP_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Equal-tempered phase increment for a 2^20 accumulator at 48 kHz.
    // Note 1 is A1 (55 Hz); each group of 12 notes is one octave, so the
    // base semitone value is shifted left by the octave index.
    function automatic logic [STEP_W-1:0] note_step(input logic [NOTE_W-1:0] n);
        logic [NOTE_W-1:0] k;
        logic [3:0]        semi;
        logic [STEP_W-1:0] base;
        if (n == NOTE_W'(0)) begin
            return STEP_W'(0);
        end
        k    = n - NOTE_W'(1);
        semi = 4'(k % NOTE_W'(12));
        case (semi)
            4'd0:    base = STEP_W'(1201);
            4'd1:    base = STEP_W'(1273);
            4'd2:    base = STEP_W'(1349);
            4'd3:    base = STEP_W'(1429);
            4'd4:    base = STEP_W'(1514);
            4'd5:    base = STEP_W'(1604);
            4'd6:    base = STEP_W'(1699);
            4'd7:    base = STEP_W'(1800);
            4'd8:    base = STEP_W'(1907);
            4'd9:    base = STEP_W'(2021);
            4'd10:   base = STEP_W'(2141);
            4'd11:   base = STEP_W'(2268);
            default: base = STEP_W'(0);
        endcase
        return base << (k / NOTE_W'(12));
    endfunction

endpackage

// File: rtl/note_player_frequency_rom.sv
// frequency_rom: synchronous ROM mapping a note index to its phase increment.
//   clk   in   system clock
//   addr  in   note index (0 = rest, returns 0)
//   data  out  phase increment, one cycle after addr
module frequency_rom
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic [NOTE_W-1:0] addr,
    output logic [STEP_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= note_step(addr);
    end

endmodule

// File: rtl/note_player.sv
// note_player: accepts one note+duration per new_note, drives the phase increment
// for the sample generator and times the duration in beats, then pulses note_done.
//   clk, reset     system clock, synchronous active-high reset
//   play           1 = run, 0 = pause (count frozen, output silenced)
//   ff_switch0     1 = consume two beats per beat pulse
//   beat           one-cycle beat pulse
//   note, duration note payload, sampled on new_note
//   new_note       one-cycle load strobe
//   note_done      one-cycle pulse when the current note's duration elapsed
//   busy           high while a note is loaded and not yet done
//   step_size      phase increment, 0 = silence
module note_player
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              ff_switch0,
    input  logic              beat,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              new_note,
    output logic              note_done,
    output logic              busy,
    output logic [STEP_W-1:0] step_size
);

    state_t            state, state_n;
    logic [DUR_W-1:0]  remaining, remaining_n;
    logic [NOTE_W-1:0] note_q, note_n;
    logic              load;
    logic              fresh;
    logic [DUR_W-1:0]  dec;
    logic [STEP_W-1:0] rom_q;
    logic              sound;

    frequency_rom u_rom (
        .clk  (clk),
        .addr (note_q),
        .data (rom_q)
    );

    // Next-state, countdown and load decode.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        note_n      = note_q;
        load        = 1'b0;
        dec         = ff_switch0 ? DUR_W'(2) : DUR_W'(1);
        case (state)
            ST_IDLE: begin
                load = new_note;
            end
            ST_PLAYING: begin
                if (new_note) begin
                    load = 1'b1;
                end else if (play) begin
                    if (remaining == DUR_W'(0)) begin
                        state_n = ST_DONE;
                    end else if (beat) begin
                        remaining_n = (remaining > dec) ? remaining - dec : DUR_W'(0);
                    end
                end
            end
            ST_DONE: begin
                load    = new_note;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (load) begin
            state_n     = ST_PLAYING;
            remaining_n = duration;
            note_n      = note;
        end
        // The ROM output lags note_q by a cycle, so the cycle right after a
        // load (fresh) still carries the previous note's value and is muted.
        sound = (state_n == ST_PLAYING) && !load && !fresh && play && (note_q != NOTE_W'(0));
    end

    // State, payload and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= DUR_W'(0);
            note_q    <= NOTE_W'(0);
            fresh     <= 1'b0;
            busy      <= 1'b0;
            note_done <= 1'b0;
            step_size <= STEP_W'(0);
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            note_q    <= note_n;
            fresh     <= load;
            busy      <= (state_n == ST_PLAYING);
            note_done <= (state_n == ST_DONE);
            step_size <= sound ? rom_q : STEP_W'(0);
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player.
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        ff_switch0;
    logic        beat;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        new_note;
    logic        note_done;
    logic        busy;
    logic [19:0] step_size;

    int n_cmp = 0;
    int n_bad = 0;
    int done_count = 0;
    int run = 0;
    int max_run = 0;

    note_player dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .ff_switch0 (ff_switch0),
        .beat       (beat),
        .note       (note),
        .duration   (duration),
        .new_note   (new_note),
        .note_done  (note_done),
        .busy       (busy),
        .step_size  (step_size)
    );

    always #5 clk = ~clk;

    // Count note_done pulses and the longest run of consecutive high cycles.
    always @(negedge clk) begin
        if (note_done) begin
            done_count++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    // One clock: drive beat for this edge, then sample just after it.
    task automatic tick_b(input logic b);
        beat = b;
        @(posedge clk);
        #1;
        beat = 1'b0;
    endtask

    task automatic load_note(input logic [5:0] n, input logic [5:0] d, input logic b);
        note     = n;
        duration = d;
        new_note = 1'b1;
        tick_b(b);
        new_note = 1'b0;
    endtask

    // n beats, 8 clocks apart; counts note_done highs and busy lows seen on the way.
    task automatic beats(input int n, output int early, output int blow);
        early = 0;
        blow  = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 8; c++) begin
                tick_b(c == 7);
                if (note_done) early++;
                if (!busy) blow++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; ff_switch0 = 1'b0; beat = 1'b0;
        note = '0; duration = '0; new_note = 1'b0;
        tick_b(0);
        tick_b(0);
        n_cmp++; if (note_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", note_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL reset_step got %0d want 0", step_size); end
        reset = 1'b0;
        tick_b(0);
    endtask

    task automatic test_basic();
        int e, bl;
        load_note(6'd1, 6'd4, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_t1 got %b want 1", busy); end
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL basic_step_t1 got %0d want 0", step_size); end
        tick_b(0);
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL basic_step_t2 got %0d want 0", step_size); end
        tick_b(0);
        n_cmp++; if (step_size !== 20'd1201) begin n_bad++; $display("FAIL basic_step_t3 got %0d want 1201", step_size); end
        beats(4, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL basic_early_done got %0d want 0", e); end
        n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL basic_busy_drop got %0d want 0", bl); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL basic_done got %b want 1", note_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL basic_step_at_done got %0d want 0", step_size); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", note_done); end
    endtask

    task automatic test_fast_forward();
        int e, bl;
        ff_switch0 = 1'b1;
        load_note(6'd1, 6'd5, 1'b0);
        beats(3, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL ff_early_done got %0d want 0", e); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ff_busy got %b want 1", busy); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL ff_done got %b want 1", note_done); end
        tick_b(0);
        ff_switch0 = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ff_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_pause();
        int e, bl;
        load_note(6'd1, 6'd4, 1'b0);
        beats(2, e, bl);
        play = 1'b0;
        tick_b(0);
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL pause_step got %0d want 0", step_size); end
        beats(5, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL pause_done got %0d want 0", e); end
        n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL pause_busy got %0d want 0", bl); end
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL pause_step_end got %0d want 0", step_size); end
        play = 1'b1;
        tick_b(0);
        n_cmp++; if (step_size !== 20'd1201) begin n_bad++; $display("FAIL resume_step got %0d want 1201", step_size); end
        beats(2, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL resume_early got %0d want 0", e); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL resume_done got %b want 1", note_done); end
        tick_b(0);
    endtask

    task automatic test_rest_and_zero();
        int e, bl;
        load_note(6'd0, 6'd2, 1'b0);
        tick_b(0);
        tick_b(0);
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL rest_step got %0d want 0", step_size); end
        beats(2, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL rest_early got %0d want 0", e); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL rest_done got %b want 1", note_done); end
        tick_b(0);
        load_note(6'd5, 6'd0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy got %b want 1", busy); end
        n_cmp++; if (note_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_t1 got %b want 0", note_done); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL zero_done_t2 got %b want 1", note_done); end
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL zero_step got %0d want 0", step_size); end
        tick_b(0);
    endtask

    task automatic test_reset_mid_note();
        int e, bl, d0;
        load_note(6'd13, 6'd6, 1'b0);
        tick_b(0);
        tick_b(0);
        n_cmp++; if (step_size !== 20'd2402) begin n_bad++; $display("FAIL n13_step got %0d want 2402", step_size); end
        beats(2, e, bl);
        reset = 1'b1;
        tick_b(0);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (step_size !== 20'd0) begin n_bad++; $display("FAIL midrst_step got %0d want 0", step_size); end
        n_cmp++; if (note_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", note_done); end
        d0 = done_count;
        beats(5, e, bl);
        n_cmp++; if (done_count !== d0) begin n_bad++; $display("FAIL midrst_ghost_done got %0d want %0d", done_count, d0); end
        load_note(6'd30, 6'd1, 1'b0);
        tick_b(0);
        tick_b(0);
        n_cmp++; if (step_size !== 20'd6416) begin n_bad++; $display("FAIL n30_step got %0d want 6416", step_size); end
        beats(1, e, bl);
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL n30_done got %b want 1", note_done); end
        tick_b(0);
    endtask

    task automatic test_reload();
        int e, bl, d0;
        // Beat coinciding with the load must not be counted.
        load_note(6'd1, 6'd1, 1'b1);
        beats(1, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL loadbeat_early got %0d want 0", e); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL loadbeat_done got %b want 1", note_done); end
        // Load while in DONE: accepted immediately.
        d0 = done_count;
        load_note(6'd5, 6'd3, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL done_reload_busy got %b want 1", busy); end
        tick_b(0);
        tick_b(0);
        n_cmp++; if (step_size !== 20'd1514) begin n_bad++; $display("FAIL n5_step got %0d want 1514", step_size); end
        beats(2, e, bl);
        // Abort with 1 beat left, reload with 3.
        load_note(6'd1, 6'd3, 1'b0);
        tick_b(0);
        tick_b(0);
        n_cmp++; if (step_size !== 20'd1201) begin n_bad++; $display("FAIL abort_step got %0d want 1201", step_size); end
        beats(3, e, bl);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL abort_early got %0d want 0", e); end
        n_cmp++; if (done_count !== d0 + 1) begin n_bad++; $display("FAIL abort_done_count got %0d want %0d", done_count, d0 + 1); end
        tick_b(0);
        n_cmp++; if (note_done !== 1'b1) begin n_bad++; $display("FAIL abort_done got %b want 1", note_done); end
        tick_b(0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] notes [8];
        logic [5:0] durs  [8];
        int d0, low_in_note, cyc, waited, timeouts, gap_bad;
        notes = '{6'd1, 6'd5, 6'd13, 6'd30, 6'd0, 6'd2, 6'd12, 6'd63};
        durs  = '{6'd1, 6'd2, 6'd0, 6'd3, 6'd1, 6'd2, 6'd1, 6'd1};
        d0 = done_count;
        low_in_note = 0;
        timeouts = 0;
        gap_bad = 0;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            note = notes[k];
            duration = durs[k];
            new_note = 1'b1;
            tick_b((cyc % 4) == 3);
            cyc++;
            new_note = 1'b0;
            if (!busy) gap_bad++;
            waited = 0;
            while (!note_done && waited < 200) begin
                tick_b((cyc % 4) == 3);
                cyc++;
                waited++;
                if (!busy) low_in_note++;
            end
            if (!note_done) timeouts++;
            // Reader responds one cycle later, from IDLE.
            tick_b((cyc % 4) == 3);
            cyc++;
            if (busy || note_done) gap_bad++;
        end
        n_cmp++; if (timeouts !== 0) begin n_bad++; $display("FAIL b2b_timeout got %0d want 0", timeouts); end
        n_cmp++; if (done_count - d0 !== 8) begin n_bad++; $display("FAIL b2b_done_count got %0d want 8", done_count - d0); end
        n_cmp++; if (low_in_note !== 8) begin n_bad++; $display("FAIL b2b_busy_low got %0d want 8", low_in_note); end
        n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL b2b_gap got %0d want 0", gap_bad); end
        n_cmp++; if (max_run !== 1) begin n_bad++; $display("FAIL done_width got %0d want 1", max_run); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fast_forward();
        test_pause();
        test_rest_and_zero();
        test_reset_mid_note();
        test_reload();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
